panda_srgate: RTL and testbench

- Set/reset latch (SR gate) for the PandA position/bit bus.
- Sets or clears a single registered bit output on selectable edges of two bit-bus inputs, set_i and rst_i.
- Register-interface force controls override the edge logic.
- Sits between the bit bus and the block register bank; its output feeds back onto the bit bus.

---
 rtl/panda_srgate.sv | 45 ++++
 tb/tb_panda_srgate.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/panda_srgate.sv
// panda_srgate: edge-triggered set/reset gate for the bit bus; SRGATE_CHANGE_PULSE_EN adds a chg_o pulse after each out_o change.
module panda_srgate #(
  parameter logic OUT_RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic set_i,
  input  logic rst_i,
  input  logic SET_EDGE,
  input  logic RESET_EDGE,
  input  logic FORCE_SET,
  input  logic FORCE_RESET,
`ifdef SRGATE_CHANGE_PULSE_EN
  output logic chg_o,
`endif
  output logic out_o
);
  logic out_q, out_d, set_prev_q, set_prev_d, rst_prev_q, rst_prev_d, set_evt, rst_evt;
  always_comb begin
    set_evt    = SET_EDGE ? (~set_i & set_prev_q) : (set_i & ~set_prev_q);
    rst_evt    = RESET_EDGE ? (~rst_i & rst_prev_q) : (rst_i & ~rst_prev_q);
    out_d      = FORCE_RESET ? 1'b0 : FORCE_SET ? 1'b1 : rst_evt ? 1'b0 : set_evt ? 1'b1 : out_q;
    set_prev_d = set_i;
    rst_prev_d = rst_i;
  end
  // Previous samples load the live inputs during reset so release never sees an edge.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_q      <= OUT_RESET_VAL;
      set_prev_q <= set_i;
      rst_prev_q <= rst_i;
    end else begin
      out_q      <= out_d;
      set_prev_q <= set_prev_d;
      rst_prev_q <= rst_prev_d;
    end
  end
  assign out_o = out_q;
`ifdef SRGATE_CHANGE_PULSE_EN
  logic chg_q, chg_d;
  always_comb chg_d = out_d != out_q;
  always_ff @(posedge clk_i) chg_q <= reset_n_i ? chg_d : 1'b0;
  assign chg_o = chg_q;
`endif
endmodule

// File: tb/tb_panda_srgate.sv
// tb_panda_srgate: directed vectors {reset_n, FORCE_RESET, FORCE_SET, set_i, rst_i, expected out_o} per scenario.
module tb_panda_srgate;
  logic clk_i = 1'b0, reset_n_i = 1'b0, set_i = 1'b1, rst_i = 1'b0;
  logic SET_EDGE = 1'b0, RESET_EDGE = 1'b0, FORCE_SET = 1'b0, FORCE_RESET = 1'b0;
  logic out_o, last = 1'b0;
  int pass_cnt = 0, total_cnt = 0;
`ifdef SRGATE_CHANGE_PULSE_EN
  logic chg_o;
`endif
  panda_srgate dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .set_i(set_i), .rst_i(rst_i),
    .SET_EDGE(SET_EDGE), .RESET_EDGE(RESET_EDGE), .FORCE_SET(FORCE_SET), .FORCE_RESET(FORCE_RESET),
`ifdef SRGATE_CHANGE_PULSE_EN
    .chg_o(chg_o),
`endif
    .out_o(out_o)
  );
  always #5 clk_i = ~clk_i;

  task automatic test_reset;
    logic [5:0] v [5] = '{6'b0_00_10_0, 6'b0_00_10_0, 6'b0_00_10_0, 6'b1_00_10_0, 6'b1_00_10_0};
    for (int i = 0; i < 5; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL reset[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== (reset_n_i && v[i][0] != last)) $display("FAIL reset_chg[%0d] chg_o=%b", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  task automatic test_rising;
    logic [5:0] v [6] = '{6'b1_00_00_0, 6'b1_00_10_1, 6'b1_00_10_1, 6'b1_00_11_0, 6'b1_00_01_0, 6'b1_00_00_0};
    {SET_EDGE, RESET_EDGE} = 2'b00;
    for (int i = 0; i < 6; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL rising[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== (reset_n_i && v[i][0] != last)) $display("FAIL rising_chg[%0d] chg_o=%b", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  task automatic test_falling;
    logic [5:0] v [4] = '{6'b1_00_10_0, 6'b1_00_00_1, 6'b1_00_01_1, 6'b1_00_00_0};
    {SET_EDGE, RESET_EDGE} = 2'b11;
    for (int i = 0; i < 4; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL falling[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== (reset_n_i && v[i][0] != last)) $display("FAIL falling_chg[%0d] chg_o=%b", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  task automatic test_simultaneous;
    logic [5:0] v [6] = '{6'b1_00_10_1, 6'b1_00_00_1, 6'b1_00_11_0, 6'b1_00_00_0, 6'b1_00_10_1, 6'b1_00_00_1};
    {SET_EDGE, RESET_EDGE} = 2'b00;
    for (int i = 0; i < 6; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL simultaneous[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== (reset_n_i && v[i][0] != last)) $display("FAIL simultaneous_chg[%0d] chg_o=%b", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] v [7] = '{6'b1_00_10_1, 6'b1_00_00_1, 6'b1_00_10_1, 6'b1_00_01_0, 6'b1_00_00_0, 6'b1_00_01_0, 6'b1_00_00_0};
    for (int i = 0; i < 7; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL back_to_back[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== (reset_n_i && v[i][0] != last)) $display("FAIL back_to_back_chg[%0d] chg_o=%b", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  task automatic test_force;
    logic [5:0] v [11] = '{6'b1_01_00_1, 6'b1_00_00_1, 6'b1_00_00_1, 6'b1_10_10_0, 6'b1_00_10_0, 6'b1_01_10_1,
                          6'b1_11_10_0, 6'b1_11_10_0, 6'b1_00_10_0, 6'b1_01_11_1, 6'b1_00_10_1};
    for (int i = 0; i < 11; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL force[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== (reset_n_i && v[i][0] != last)) $display("FAIL force_chg[%0d] chg_o=%b", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  task automatic test_edge_select_static;
    logic [5:0] v [3] = '{6'b1_00_10_1, 6'b1_00_10_1, 6'b1_00_10_1};
    for (int i = 0; i < 3; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      SET_EDGE = (i == 1);
      RESET_EDGE = (i == 1);
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL edge_static[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== 1'b0) $display("FAIL edge_static_chg[%0d] chg_o=%b expected 0", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  task automatic test_mid_reset;
    logic [5:0] v [7] = '{6'b1_00_00_1, 6'b0_00_10_0, 6'b1_00_10_0, 6'b1_00_00_0, 6'b1_00_10_1, 6'b0_00_00_0, 6'b1_00_00_0};
    {SET_EDGE, RESET_EDGE} = 2'b00;
    for (int i = 0; i < 7; i++) begin
      {reset_n_i, FORCE_RESET, FORCE_SET, set_i, rst_i} = v[i][5:1];
      @(posedge clk_i); #1;
      total_cnt++;
      if (out_o !== v[i][0]) $display("FAIL mid_reset[%0d] out_o=%b expected %b", i, out_o, v[i][0]); else pass_cnt++;
`ifdef SRGATE_CHANGE_PULSE_EN
      total_cnt++;
      if (chg_o !== (reset_n_i && v[i][0] != last)) $display("FAIL mid_reset_chg[%0d] chg_o=%b", i, chg_o); else pass_cnt++;
`endif
      last = v[i][0];
    end
  endtask

  initial begin
    test_reset;
    test_rising;
    test_falling;
    test_simultaneous;
    test_back_to_back;
    test_force;
    test_edge_select_static;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
